// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, shifter, HI/LO registers, single-cycle multiplier and
// a 32-iteration restoring divider that stalls the pipeline while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct_in,
    input  logic [31:0] operand_1_in,
    input  logic [31:0] operand_2_in,
    input  logic [4:0]  shamt_in,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_reg_addr_in,
    output logic [31:0] result_out,
    output logic        write_reg_en_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        stall_req
);
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t         state, state_next;
    logic [5:0]         count;
    logic [31:0]        hi, lo;
    logic [31:0]        div_rem, div_quo, div_dsr;
    logic               quo_neg, rem_neg;
    logic               stall_core;

    logic signed [31:0] op1_s, op2_s;
    logic signed [63:0] op1_wide, op2_wide, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        sum, diff;
    logic               add_ovf, sub_ovf;
    logic               is_div, is_signed_div, div_start;

    logic [32:0]        div_shifted;
    logic               div_ge;
    logic [31:0]        div_trial, div_rem_next;

    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    assign op1_s    = operand_1_in;
    assign op2_s    = operand_2_in;
    assign op1_wide = {{32{operand_1_in[31]}}, operand_1_in};
    assign op2_wide = {{32{operand_2_in[31]}}, operand_2_in};
    assign prod_s   = op1_wide * op2_wide;
    assign prod_u   = {32'd0, operand_1_in} * {32'd0, operand_2_in};

    assign sum     = operand_1_in + operand_2_in;
    assign diff    = operand_1_in - operand_2_in;
    assign add_ovf = (operand_1_in[31] == operand_2_in[31]) && (sum[31]  != operand_1_in[31]);
    assign sub_ovf = (operand_1_in[31] != operand_2_in[31]) && (diff[31] != operand_1_in[31]);

    assign is_div        = (funct_in == F_DIV) || (funct_in == F_DIVU);
    assign is_signed_div = (funct_in == F_DIV);
    assign div_start     = is_div && (operand_2_in != 32'd0);

    always_comb begin
        result_out = 32'd0;
        case (funct_in)
            F_SLL:   result_out = operand_2_in << shamt_in;
            F_SRL:   result_out = operand_2_in >> shamt_in;
            F_SRA:   result_out = $unsigned(op2_s >>> shamt_in);
            F_SLLV:  result_out = operand_2_in << operand_1_in[4:0];
            F_SRLV:  result_out = operand_2_in >> operand_1_in[4:0];
            F_SRAV:  result_out = $unsigned(op2_s >>> operand_1_in[4:0]);
            F_MFHI:  result_out = hi;
            F_MFLO:  result_out = lo;
            F_ADD, F_ADDU: result_out = sum;
            F_SUB, F_SUBU: result_out = diff;
            F_AND:   result_out = operand_1_in & operand_2_in;
            F_OR:    result_out = operand_1_in | operand_2_in;
            F_XOR:   result_out = operand_1_in ^ operand_2_in;
            F_NOR:   result_out = ~(operand_1_in | operand_2_in);
            F_SLT:   result_out = {31'd0, op1_s < op2_s};
            F_SLTU:  result_out = {31'd0, operand_1_in < operand_2_in};
            default: result_out = 32'd0;
        endcase
    end

    // Signed overflow on ADD/SUB drops the register write instead of trapping.
    assign write_reg_en_out   = write_reg_en_in &&
                                !((funct_in == F_ADD && add_ovf) || (funct_in == F_SUB && sub_ovf));
    assign write_reg_addr_out = write_reg_addr_in;

    always_comb begin
        state_next = state;
        stall_core = 1'b0;
        case (state)
            IDLE: begin
                if (div_start) begin
                    state_next = BUSY;
                    stall_core = 1'b1;
                end
            end
            BUSY: begin
                stall_core = 1'b1;
                if (count == 6'd31)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_req = stall_core && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 6'd0;
        end else begin
            state <= state_next;
            if (state == IDLE)
                count <= 6'd0;
            else if (state == BUSY)
                count <= count + 6'd1;
        end
    end

    // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    assign div_shifted  = {div_rem, div_quo[31]};
    assign div_ge       = div_shifted >= {1'b0, div_dsr};
    assign div_trial    = div_shifted[31:0] - div_dsr;
    assign div_rem_next = div_ge ? div_trial : div_shifted[31:0];

    always_ff @(posedge clk) begin
        if (state == IDLE && div_start) begin
            div_quo <= is_signed_div ? apply_sign(operand_1_in, operand_1_in[31]) : operand_1_in;
            div_dsr <= is_signed_div ? apply_sign(operand_2_in, operand_2_in[31]) : operand_2_in;
            div_rem <= 32'd0;
            quo_neg <= is_signed_div && (operand_1_in[31] ^ operand_2_in[31]);
            rem_neg <= is_signed_div && operand_1_in[31];
        end else if (state == BUSY) begin
            div_rem <= div_rem_next;
            div_quo <= {div_quo[30:0], div_ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == DONE) begin
            lo <= apply_sign(div_quo, quo_neg);
            hi <= apply_sign(div_rem, rem_neg);
        end else if (!stall_req) begin
            case (funct_in)
                F_MTHI:  hi <= operand_1_in;
                F_MTLO:  lo <= operand_1_in;
                F_MULT:  {hi, lo} <= prod_s;
                F_MULTU: {hi, lo} <= prod_u;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed corner cases followed by random operations,
// all checked against an arithmetic model of the execute stage.
module tb_ex_stage;
    logic        clk;
    logic        rst;
    logic [5:0]  funct_in;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic [4:0]  shamt_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        stall_req;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    ex_stage dut (
        .clk                (clk),
        .rst                (rst),
        .funct_in           (funct_in),
        .operand_1_in       (operand_1_in),
        .operand_2_in       (operand_2_in),
        .shamt_in           (shamt_in),
        .write_reg_en_in    (write_reg_en_in),
        .write_reg_addr_in  (write_reg_addr_in),
        .result_out         (result_out),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out),
        .stall_req          (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_comb(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] sh, input logic we,
                                       output logic [31:0] r, output logic w);
        int     sa, sb;
        longint la, lb, s;
        longint maxi, mini;
        sa = a; sb = b; la = sa; lb = sb;
        maxi = 2147483647; mini = -maxi - 1;
        r = 32'd0;
        w = we;
        case (f)
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = sb >>> sh;
            6'h04: r = b << a[4:0];
            6'h06: r = b >> a[4:0];
            6'h07: r = sb >>> a[4:0];
            6'h10: r = hi_m;
            6'h12: r = lo_m;
            6'h20, 6'h21: begin
                r = a + b;
                s = la + lb;
                if (f == 6'h20 && (s > maxi || s < mini)) w = 1'b0;
            end
            6'h22, 6'h23: begin
                r = a - b;
                s = la - lb;
                if (f == 6'h22 && (s > maxi || s < mini)) w = 1'b0;
            end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
    endfunction

    function automatic void model_seq(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int              sa, sb;
        longint          la, lb, q, rm;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = a; sb = b; la = sa; lb = sb; ua = a; ub = b;
        case (f)
            6'h11: hi_m = a;
            6'h13: lo_m = a;
            6'h18: begin p = la * lb; hi_m = p[63:32]; lo_m = p[31:0]; end
            6'h19: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
            6'h1A: if (b != 0) begin
                q = la / lb; rm = la % lb;
                p = q;  lo_m = p[31:0];
                p = rm; hi_m = p[31:0];
            end
            6'h1B: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            default: ;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic we, input logic [4:0] wa);
        logic [31:0] er;
        logic        ew;
        logic        dv;
        int          n;
        @(negedge clk);
        funct_in = f; operand_1_in = a; operand_2_in = b;
        shamt_in = sh; write_reg_en_in = we; write_reg_addr_in = wa;
        #1;
        model_comb(f, a, b, sh, we, er, ew);
        dv = (f == 6'h1A || f == 6'h1B) && (b != 32'd0);
        chk({tag, ".result"}, result_out, er);
        chk({tag, ".wen"},    {31'd0, write_reg_en_out}, {31'd0, ew});
        chk({tag, ".waddr"},  {27'd0, write_reg_addr_out}, {27'd0, wa});
        chk({tag, ".stall"},  {31'd0, stall_req}, {31'd0, dv});
        if (dv) begin
            n = 0;
            while (stall_req === 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
                #1;
            end
            chk({tag, ".stall_len"}, n, 32'd33);
            chk({tag, ".stall_drop"}, {31'd0, stall_req}, 32'd0);
        end
        model_seq(f, a, b);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return edges[$urandom_range(0, 4)];
            default: return -32'($urandom_range(1, 20));
        endcase
    endfunction

    initial begin
        logic [5:0] codes [24];
        logic [5:0] f;
        codes = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13,
                  6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                  6'h26, 6'h27, 6'h2A, 6'h2B};

        rst = 1'b1;
        funct_in = 6'h0; operand_1_in = 32'h0; operand_2_in = 32'h0;
        shamt_in = 5'h0; write_reg_en_in = 1'b0; write_reg_addr_in = 5'h0;
        #1;
        chk("reset.result", result_out, 32'h0);
        chk("reset.wen",    {31'd0, write_reg_en_out}, 32'h0);
        chk("reset.waddr",  {27'd0, write_reg_addr_out}, 32'h0);
        chk("reset.stall",  {31'd0, stall_req}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("mfhi_after_reset", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd3);
        do_op("mflo_after_reset", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd3);

        // Reset in the middle of a divide
        do_op("mthi_pre", 6'h11, 32'hAAAA_0001, 32'h0, 5'd0, 1'b0, 5'd0);
        do_op("mtlo_pre", 6'h13, 32'hBBBB_0002, 32'h0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        funct_in = 6'h1B; operand_1_in = 32'd100; operand_2_in = 32'd7;
        #1;
        chk("middiv.stall_start", {31'd0, stall_req}, 32'd1);
        repeat (9) @(negedge clk);
        #1;
        chk("middiv.stall_busy", {31'd0, stall_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("middiv.stall_on_rst", {31'd0, stall_req}, 32'd0);
        funct_in = 6'h0; operand_1_in = 32'h0; operand_2_in = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        hi_m = 32'h0; lo_m = 32'h0;
        do_op("middiv.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd4);
        do_op("middiv.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd4);

        // Directed arithmetic and shift corners
        do_op("addu_wrap", 6'h21, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 5'd5);
        chk("addu_wrap.literal", result_out, 32'h0);
        do_op("add_ovf", 6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b1, 5'd6);
        chk("add_ovf.wen_literal", {31'd0, write_reg_en_out}, 32'd0);
        do_op("sub_ovf", 6'h22, 32'h8000_0000, 32'h1, 5'd0, 1'b1, 5'd6);
        do_op("slt_neg", 6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 5'd7);
        chk("slt_neg.literal", result_out, 32'd1);
        do_op("sltu_big", 6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1, 5'd7);
        chk("sltu_big.literal", result_out, 32'd0);
        do_op("sra", 6'h03, 32'h0, 32'h8000_0000, 5'd4, 1'b1, 5'd8);
        chk("sra.literal", result_out, 32'hF800_0000);
        do_op("srlv", 6'h06, 32'h24, 32'h8000_0000, 5'd0, 1'b1, 5'd8);
        chk("srlv.literal", result_out, 32'h0800_0000);

        // Multiply then read back
        do_op("mult", 6'h18, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b0, 5'd0);
        do_op("mult.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd9);
        chk("mult.hi_literal", result_out, 32'hFFFF_FFFF);
        do_op("mult.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd9);
        chk("mult.lo_literal", result_out, 32'hFFFF_FFFE);
        do_op("multu", 6'h19, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b0, 5'd0);
        do_op("multu.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd9);
        chk("multu.hi_literal", result_out, 32'h1);
        do_op("multu.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd9);
        chk("multu.lo_literal", result_out, 32'hFFFF_FFFE);

        // Signed divide with mixed signs
        do_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'h2, 5'd0, 1'b0, 5'd0);
        do_op("div.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd10);
        chk("div.lo_literal", result_out, 32'hFFFF_FFFD);
        do_op("div.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd10);
        chk("div.hi_literal", result_out, 32'hFFFF_FFFF);

        // Divide by zero leaves HI/LO alone
        do_op("mthi", 6'h11, 32'h1234, 32'h0, 5'd0, 1'b0, 5'd0);
        do_op("mtlo", 6'h13, 32'h5678, 32'h0, 5'd0, 1'b0, 5'd0);
        do_op("divu_by0", 6'h1B, 32'd5, 32'd0, 5'd0, 1'b0, 5'd0);
        do_op("divu_by0.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd11);
        chk("divu_by0.hi_literal", result_out, 32'h1234);
        do_op("divu_by0.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd11);
        chk("divu_by0.lo_literal", result_out, 32'h5678);

        // Back-to-back divides
        do_op("b2b_div1", 6'h1B, 32'hFFFF_FFFF, 32'd10, 5'd0, 1'b0, 5'd0);
        do_op("b2b_div2", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0, 5'd0);
        do_op("b2b.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd12);
        do_op("b2b.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd12);

        // Random operations against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                f = 6'($urandom_range(0, 63));
            else
                f = codes[$urandom_range(0, 23)];
            do_op("rand", f, rand_operand(), rand_operand(), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        do_op("final.mfhi", 6'h10, 32'h0, 32'h0, 5'd0, 1'b1, 5'd1);
        do_op("final.mflo", 6'h12, 32'h0, 32'h0, 5'd0, 1'b1, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS integer pipeline.
- Consumes the registered outputs of the ID/EX pipeline register and computes the ALU result, forwarding it with the writeback control to the EX/MEM register.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration restoring divider.
- Raises a stall request while a divide is in progress.

Parameters:
- None. Widths are fixed by the global bus macros: data 32, funct 6, shamt 5, register address 5.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- funct_in  in  6  operation code (MIPS R-type funct encoding)
- operand_1_in  in  32  rs value
- operand_2_in  in  32  rt value or extended immediate
- shamt_in  in  5  constant shift amount
- write_reg_en_in  in  1  GPR write enable from ID
- write_reg_addr_in  in  5  destination GPR
- result_out  out  32  ALU/move result (combinational)
- write_reg_en_out  out  1  GPR write enable to EX/MEM
- write_reg_addr_out  out  5  passthrough of write_reg_addr_in
- stall_req  out  1  high: hold PC, IF/ID and ID/EX; insert bubble into EX/MEM

Behaviour:
- State: hi, lo (32 each), FSM {IDLE, BUSY, DONE}, 6-bit iteration count, divider working registers.
- Reset (async, any time including mid-divide): hi=lo=0, FSM=IDLE, count=0, stall_req=0.
  - With all-zero inputs, result_out=0, write_reg_en_out=0, write_reg_addr_out=0.
- Combinational results (funct hex):
  - Shifts, all on operand_2:
    - SLL 00, SRL 02, SRA 03 use shamt_in.
    - SLLV 04, SRLV 06, SRAV 07 use operand_1[4:0].
  - Moves from HI/LO: MFHI 10 -> hi, MFLO 12 -> lo.
  - Add/subtract, modulo 2^32: ADD 20, ADDU 21, SUB 22, SUBU 23.
  - Logic: AND 24, OR 25, XOR 26, NOR 27.
  - Compares (result 1/0): SLT 2A signed, SLTU 2B unsigned.
  - Any other funct: result_out=0.
- ADD/SUB signed overflow: write_reg_en_out=0 (write suppressed; no exception). Otherwise write_reg_en_out=write_reg_en_in.
- HI/LO writes, at the clock edge while the op is in EX and stall_req=0:
  - MTHI 11: hi<=operand_1.
  - MTLO 13: lo<=operand_1.
  - MULT 18 signed, MULTU 19 unsigned: {hi,lo}<=operand_1*operand_2, 64-bit product.
- Divide, DIV 1A signed / DIVU 1B unsigned:
  - IDLE with divide funct and operand_2!=0:
    - stall_req=1 combinationally.
    - At the edge, latch |dividend|, |divisor| (magnitude for DIV, raw for DIVU) and result signs; count<=0; ->BUSY.
  - BUSY:
    - stall_req=1.
    - One restoring shift-subtract iteration per cycle; count++.
    - After the 32nd iteration (count==31 at edge) ->DONE.
  - DONE:
    - stall_req=0, so the pipeline advances at this edge.
    - lo<=quotient, hi<=remainder. For DIV: quotient negated if operand signs differ; remainder takes the dividend's sign.
    - ->IDLE.
  - stall_req is therefore high for exactly 33 consecutive cycles per divide. A back-to-back divide restarts from IDLE on the next cycle.
  - Divide by zero: no stall, hi/lo unchanged, FSM stays IDLE.
  - Inputs are held stable by the upstream freeze during stall; the divider uses only its latched copies.
- Divides write no GPR; write_reg_en_out follows write_reg_en_in (0 from ID).
- An MFHI/MFLO in the cycle after DONE, MULT or MTHI/MTLO reads the updated value.

Test Plan:
- Reset mid-divide: start DIVU 100/7, assert rst at cycle 10 -> stall_req=0 immediately; hi=lo=0; FSM IDLE.
- ADDU 0xFFFFFFFF+1 -> result_out=0, write_reg_en_out=1. ADD 0x7FFFFFFF+1 -> write_reg_en_out=0. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0.
- SRA operand_2=0x80000000, shamt=4 -> 0xF8000000. SRLV operand_1=0x24, operand_2=0x80000000 -> 0x08000000.
- MULT 0xFFFFFFFF*2 then MFHI/MFLO -> 0xFFFFFFFF/0xFFFFFFFE. MULTU with the same operands -> hi=1, lo=0xFFFFFFFE.
- DIV -7/2:
  - stall_req high for exactly 33 cycles, then low 1 cycle.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - An MFLO immediately after returns 0xFFFFFFFD.
- DIVU 5/0 -> stall_req never asserts; hi/lo retain the prior MTHI 0x1234 / MTLO 0x5678 values.
